fifo_umbral: RTL and testbench

FIFO_UMBRAL -- requirements
Module: fifo_umbral

---
 rtl/fifo_umbral_pkg.sv | 15 +
 rtl/fifo_umbral_mem_fifo.sv | 27 ++
 rtl/fifo_umbral.sv | 113 +++++++++++
 tb/tb_fifo_umbral.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbral_pkg.sv
// rtl/fifo_umbral_pkg.sv - shared defaults and depth constant for the threshold FIFO
package fifo_umbral_pkg;

    localparam int WORD_SIZE_DEF = 12;
    localparam int ADDR_SIZE_DEF = 3;
    localparam int DEPTH_DEF     = 1 << ADDR_SIZE_DEF;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_umbral_mem_fifo.sv
// rtl/fifo_umbral_mem_fifo.sv - FIFO storage: synchronous write, combinational read
module mem_fifo
    import fifo_umbral_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem_q [1 << ADDR_SIZE];

    // Contents are never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - threshold FIFO with almost-full/empty flags; FIFO_ERROR_EN adds sticky error
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 pop,
    input  logic [ADDR_SIZE:0]   umbral_af,
    input  logic [ADDR_SIZE:0]   umbral_ae,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam logic [ADDR_SIZE:0]   DEPTH_C   = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0]   CNT_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE-1:0] PTR_ONE   = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_out_q;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 push_ok, pop_ok;
    fifo_op_e             op;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= umbral_af);
    assign almost_empty = (count_q <= umbral_ae);

    // A full FIFO can still take a write when a pop frees the slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign op      = fifo_op_e'({push_ok, pop_ok});

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = rd_data;
        end
        case (op)
            OP_PUSH: count_d = count_q + CNT_ONE;
            OP_POP:  count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= pop_ok;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef FIFO_ERROR_EN
    logic error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else if ((push && full && !pop) || (pop && empty)) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    mem_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - directed self-checking bench for fifo_umbral
module tb_fifo_umbral;

`ifdef FIFO_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [11:0] data_in;
    logic        pop;
    logic [3:0]  umbral_af;
    logic [3:0]  umbral_ae;
    logic [11:0] data_out;
    logic        valid_out;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        almost_empty;
    logic        error;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_umbral dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        umbral_af = 4'd6; umbral_ae = 4'd2;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", valid_out, 0);
        check("rst_dout", data_out, 0);
        check("rst_error", error, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);

        // fill 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = 12'(i);
            cyc();
            check($sformatf("fill_af_%0d", i), almost_full, (i >= 6) ? 1 : 0);
            check($sformatf("fill_full_%0d", i), full, (i == 8) ? 1 : 0);
            check($sformatf("fill_ae_%0d", i), almost_empty, (i <= 2) ? 1 : 0);
        end
        data_in = 12'h009;
        cyc();
        push = 1'b0;
        check("ovf_full", full, 1);
        check("ovf_error", error, {31'd0, ERR_EN});

        // drain in order
        for (int k = 1; k <= 8; k++) begin
            pop = 1'b1;
            cyc();
            check($sformatf("drain_dout_%0d", k), data_out, k);
            check($sformatf("drain_valid_%0d", k), valid_out, 1);
            check($sformatf("drain_empty_%0d", k), empty, (k == 8) ? 1 : 0);
        end
        cyc();
        pop = 1'b0;
        check("unf_valid", valid_out, 0);
        check("unf_dout_hold", data_out, 12'h008);
        check("unf_error", error, {31'd0, ERR_EN});

        // steady push+pop at count 3 across pointer wrap
        umbral_af = 4'd3; umbral_ae = 4'd3;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; data_in = 12'h101 + 12'(i);
            cyc();
        end
        pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 12'h104 + 12'(k);
            cyc();
            check($sformatf("wrap_dout_%0d", k), data_out, 12'h101 + 12'(k));
            check($sformatf("wrap_cnt3_%0d", k), {almost_full, almost_empty, valid_out}, 3'b111);
        end
        push = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("wrap_tail_%0d", k), data_out, 12'h10B + 12'(k));
        end
        pop = 1'b0;
        check("wrap_empty", empty, 1);

        // push+pop while empty: no fall-through
        umbral_af = 4'd1; umbral_ae = 4'd1;
        push = 1'b1; pop = 1'b1; data_in = 12'hABC;
        cyc();
        push = 1'b0;
        check("pe_valid", valid_out, 0);
        check("pe_empty", empty, 0);
        check("pe_cnt1", {almost_full, almost_empty}, 2'b11);
        check("pe_dout_hold", data_out, 12'h10D);
        cyc();
        pop = 1'b0;
        check("pe_pop_dout", data_out, 12'hABC);
        check("pe_pop_valid", valid_out, 1);
        check("pe_pop_empty", empty, 1);

        // threshold boundaries
        umbral_af = 4'd0; umbral_ae = 4'd8;
        #1;
        check("af0_empty", almost_full, 1);
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = 12'h200 + 12'(i);
            cyc();
        end
        push = 1'b0;
        check("ae8_full", almost_empty, 1);
        umbral_ae = 4'd7;
        #1;
        check("ae7_full", almost_empty, 0);

        // full with push+pop: both accepted
        push = 1'b1; pop = 1'b1; data_in = 12'h2FF;
        cyc();
        push = 1'b0; pop = 1'b0;
        check("fpp_dout", data_out, 12'h201);
        check("fpp_full", full, 1);

        // pop to count 5 then reset mid-cycle
        pop = 1'b1;
        repeat (3) cyc();
        pop = 1'b0;
        check("pre_rst_dout", data_out, 12'h204);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_dout", data_out, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_ae", almost_empty, 1);
        check("mid_rst_af", almost_full, 1);
        @(negedge clk);
        reset = 1'b1;
        push = 1'b1; data_in = 12'h123;
        cyc();
        push = 1'b0; pop = 1'b1;
        cyc();
        pop = 1'b0;
        check("post_rst_dout", data_out, 12'h123);
        check("post_rst_valid", valid_out, 1);
        check("post_rst_empty", empty, 1);
        cyc();
        check("post_rst_idle_valid", valid_out, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
